// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-memory fetch sequencer.
// Holds the FSM state encoding, instruction width in bytes and the halt word.
package imem_pkg;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] HALT_WORD  = 32'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/imem_fetch_sequencer_if.sv
// Fetch-request / memory-port bundle between the core, the sequencer and imem.
// slave = sequencer view; master = core-and-memory environment view.
interface imem_fetch_sequencer_if #(
  parameter int ADDR_W = 6
) ();

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              flush;
  logic              fetch_ready;
  logic              inst_valid;
  logic [31:0]       instruction;
  logic              halt;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport slave (
    input  fetch_req,
    input  fetch_pc,
    input  flush,
    input  mem_rdata,
    output fetch_ready,
    output inst_valid,
    output instruction,
    output halt,
    output mem_rd,
    output mem_addr
  );

  modport master (
    output fetch_req,
    output fetch_pc,
    output flush,
    output mem_rdata,
    input  fetch_ready,
    input  inst_valid,
    input  instruction,
    input  halt,
    input  mem_rd,
    input  mem_addr
  );

endinterface

// File: rtl/imem_fetch_sequencer_packer.sv
// Big-endian byte packer: shifts bytes in MSB-first and flags the final byte.
// Ports: clk, rst (async low), clr, load, din -> word_nxt, full.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] word_nxt,
  output logic        full
);

  logic [31:0] word;
  logic [2:0]  cnt;

  assign word_nxt = {word[23:0], din};
  // Asserted on the load that completes the word.
  assign full = load && (cnt == 3'(INST_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (load) begin
      word <= word_nxt;
      cnt  <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer: four byte reads per request, big-endian assembly, halt.
// Ports: clk, rst (async low), bus (slave: fetch handshake + memory port).
module imem_fetch_sequencer
  import imem_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int MEM_BYTES = 64
) (
  input logic                   clk,
  input logic                   rst,
  imem_fetch_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_READ   = READ;
  localparam logic [1:0] S_DONE   = DONE;
  localparam logic [1:0] S_HALTED = HALTED;

  localparam logic [ADDR_W:0] LAST_PC =
    (ADDR_W + 1)'(MEM_BYTES - INST_BYTES);

  logic [1:0]        state;
  logic [1:0]        iss;
  logic              cap_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       inst_q;
  logic              valid_q;
  logic              halt_q;

  logic              ready;
  logic              accept;
  logic              in_range;
  logic              in_read;
  logic              load;
  logic              clr;
  logic              full;
  logic [31:0]       word_nxt;

  assign ready    = rst && (state == S_IDLE) && !halt_q;
  assign accept   = bus.fetch_req && ready && !bus.flush;
  assign in_range = {1'b0, bus.fetch_pc} <= LAST_PC;
  assign in_read  = (state == S_READ);
  // cap_q marks a cycle whose mem_rdata answers a read from the cycle before.
  assign load     = in_read && cap_q && !bus.flush;
  assign clr      = accept || (in_read && bus.flush);

  imem_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .din      (bus.mem_rdata),
    .word_nxt (word_nxt),
    .full     (full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      iss     <= '0;
      cap_q   <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cap_q <= 1'b0;
          if (accept) begin
            if (!in_range) begin
              state  <= S_HALTED;
              halt_q <= 1'b1;
            end else begin
              state  <= S_READ;
              rd_q   <= 1'b1;
              addr_q <= bus.fetch_pc;
              iss    <= '0;
            end
          end
        end
        S_READ: begin
          if (bus.flush) begin
            state <= S_IDLE;
            rd_q  <= 1'b0;
            cap_q <= 1'b0;
          end else begin
            cap_q <= rd_q;
            if (rd_q) begin
              if (iss == 2'd3) begin
                rd_q <= 1'b0;
              end else begin
                addr_q <= addr_q + ADDR_W'(1);
                iss    <= iss + 2'd1;
              end
            end
            if (full) begin
              inst_q  <= word_nxt;
              valid_q <= 1'b1;
              if (word_nxt == HALT_WORD) begin
                halt_q <= 1'b1;
                state  <= S_HALTED;
              end else begin
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE:   state <= S_IDLE;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.fetch_ready = ready;
  assign bus.inst_valid  = valid_q;
  assign bus.instruction = inst_q;
  assign bus.halt        = halt_q;
  assign bus.mem_rd      = rd_q;
  assign bus.mem_addr    = addr_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Self-checking bench for imem_fetch_sequencer with a registered-read memory.
// Expected words are queued at request time and popped on inst_valid.
module tb_imem_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_sequencer_if #(.ADDR_W(6)) bus ();

  imem_fetch_sequencer #(
    .ADDR_W    (6),
    .MEM_BYTES (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  mem [64];
  logic [32:0] exp_q [$];
  logic [31:0] last_word;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk)
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  always @(negedge clk) begin
    if (rst && bus.inst_valid) begin
      logic [32:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: inst_valid with word %h, none expected",
                 bus.instruction);
      end else begin
        e = exp_q.pop_front();
        if ({bus.halt, bus.instruction} !== e) begin
          errors++;
          $display("FAIL sb_word: got halt=%b inst=%h want halt=%b inst=%h",
                   bus.halt, bus.instruction, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_word = 32'h0;
    @(negedge clk);
  endtask

  task automatic fetch_once(input int pc);
    logic [31:0] w;
    logic        h;
    w = {mem[pc], mem[pc+1], mem[pc+2], mem[pc+3]};
    h = (w == 32'h0);
    checks++;
    if (bus.fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_pre pc=%0d: got %b want 1", pc, bus.fetch_ready);
    end
    exp_q.push_back({h, w});
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 6'(pc);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 6'(pc + k)) begin
        errors++;
        $display("FAIL rd_addr pc=%0d k=%0d: got rd=%b addr=%0d want rd=1 addr=%0d",
                 pc, k, bus.mem_rd, bus.mem_addr, pc + k);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.mem_rd !== 1'b0 || bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_end pc=%0d: got rd=%b valid=%b want 0 0",
               pc, bus.mem_rd, bus.inst_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.halt !== h) begin
      errors++;
      $display("FAIL valid_lat pc=%0d: got valid=%b halt=%b want 1 %b",
               pc, bus.inst_valid, bus.halt, h);
    end
    last_word = w;
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.fetch_ready !== !h) begin
      errors++;
      $display("FAIL post_done pc=%0d: got valid=%b ready=%b want 0 %b",
               pc, bus.inst_valid, bus.fetch_ready, !h);
    end
  endtask

  task automatic test_reset();
    bus.fetch_req = 1'b0;
    bus.fetch_pc  = '0;
    bus.flush     = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.fetch_ready, bus.inst_valid, bus.halt, bus.mem_rd} !== 4'b0 ||
        bus.instruction !== 32'h0 || bus.mem_addr !== 6'h0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b h=%b rd=%b inst=%h addr=%0d",
               bus.fetch_ready, bus.inst_valid, bus.halt, bus.mem_rd,
               bus.instruction, bus.mem_addr);
    end
    rst = 1'b1;
    last_word = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.fetch_ready);
    end
  endtask

  task automatic test_basic();
    fetch_once(0);
    checks++;
    if (bus.instruction !== 32'h20080005 || bus.halt !== 1'b0) begin
      errors++;
      $display("FAIL basic_word: got %h halt=%b want 20080005 halt=0",
               bus.instruction, bus.halt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    w = {mem[4], mem[5], mem[6], mem[7]};
    exp_q.push_back({1'b0, w});
    exp_q.push_back({1'b0, w});
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 6'd4;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_valid: got %b want 1", bus.inst_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.fetch_ready !== 1'b1 || bus.mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_gap: got rdy=%b rd=%b want 1 0",
               bus.fetch_ready, bus.mem_rd);
    end
    @(negedge clk);
    bus.fetch_req = 1'b0;
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 6'd4) begin
      errors++;
      $display("FAIL b2b_second_accept: got rd=%b addr=%0d want 1 4",
               bus.mem_rd, bus.mem_addr);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_valid: got %b want 1", bus.inst_valid);
    end
    last_word = w;
    @(negedge clk);
  endtask

  task automatic test_edges();
    fetch_once(13);
    fetch_once(60);
  endtask

  task automatic test_flush();
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 6'd12;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 6'd12) begin
      errors++;
      $display("FAIL flush_rd0: got rd=%b addr=%0d want 1 12",
               bus.mem_rd, bus.mem_addr);
    end
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.mem_rd !== 1'b0 || bus.fetch_ready !== 1'b1 ||
        bus.instruction !== last_word) begin
      errors++;
      $display("FAIL flush_abort: got rd=%b rdy=%b inst=%h want 0 1 %h",
               bus.mem_rd, bus.fetch_ready, bus.instruction, last_word);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet cyc=%0d: got v=%b rd=%b want 0 0",
                 i, bus.inst_valid, bus.mem_rd);
      end
    end
    fetch_once(16);
  endtask

  task automatic test_flush_idle();
    bus.fetch_req = 1'b1;
    bus.flush     = 1'b1;
    bus.fetch_pc  = 6'd20;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b0;
    checks++;
    if (bus.mem_rd !== 1'b0 || bus.fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: got rd=%b rdy=%b want 0 1",
               bus.mem_rd, bus.fetch_ready);
    end
  endtask

  task automatic test_halt_word();
    fetch_once(8);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 6'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_rd !== 1'b0 || bus.fetch_ready !== 1'b0 ||
          bus.halt !== 1'b1) begin
        errors++;
        $display("FAIL halted_ignore cyc=%0d: got rd=%b rdy=%b h=%b want 0 0 1",
                 i, bus.mem_rd, bus.fetch_ready, bus.halt);
      end
    end
    bus.fetch_req = 1'b0;
    apply_reset();
  endtask

  task automatic test_range();
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 6'd61;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    checks++;
    if (bus.halt !== 1'b1 || bus.mem_rd !== 1'b0 || bus.fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL range_halt: got h=%b rd=%b rdy=%b want 1 0 0",
               bus.halt, bus.mem_rd, bus.fetch_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL range_quiet cyc=%0d: got v=%b rd=%b want 0 0",
                 i, bus.inst_valid, bus.mem_rd);
      end
    end
    apply_reset();
  endtask

  task automatic test_async_reset();
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 6'd0;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.fetch_ready, bus.inst_valid, bus.halt, bus.mem_rd} !== 4'b0 ||
        bus.instruction !== 32'h0 || bus.mem_addr !== 6'h0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b v=%b h=%b rd=%b inst=%h addr=%0d",
               bus.fetch_ready, bus.inst_valid, bus.halt, bus.mem_rd,
               bus.instruction, bus.mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    last_word = 32'h0;
    @(negedge clk);
    fetch_once(0);
    checks++;
    if (bus.halt !== 1'b0 || bus.instruction !== 32'h20080005) begin
      errors++;
      $display("FAIL post_reset_fetch: got h=%b inst=%h want 0 20080005",
               bus.halt, bus.instruction);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h20; mem[1]  = 8'h08; mem[2]  = 8'h00; mem[3]  = 8'h05;
    mem[8] = 8'h00; mem[9]  = 8'h00; mem[10] = 8'h00; mem[11] = 8'h00;
    last_word = 32'h0;

    test_reset();
    test_basic();
    test_back_to_back();
    test_edges();
    test_flush();
    test_flush_idle();
    test_halt_word();
    test_range();
    test_async_reset();

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
Controller that sequences the byte-wide, 64-byte instruction memory on behalf of the core's fetch stage. It accepts a fetch request carrying a PC, issues four consecutive single-byte reads to a registered-read memory port, and assembles them big-endian into one 32-bit instruction. It also owns halt detection: an all-zero word or an out-of-range PC sets a sticky halt.

Parameters:
ADDR_W, 6, byte address width of instruction memory
MEM_BYTES, 64, memory depth in bytes (must equal 2**ADDR_W)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
fetch_req  input  1  core requests an instruction at fetch_pc
fetch_pc  input  ADDR_W  byte address of instruction MSB
flush  input  1  abort in-flight fetch (branch redirect)
fetch_ready  output  1  request can be accepted this cycle
inst_valid  output  1  one-cycle pulse: instruction is valid
instruction  output  32  assembled instruction word
halt  output  1  sticky halt indication
mem_rd  output  1  byte read strobe to memory
mem_addr  output  ADDR_W  byte address to memory
mem_rdata  input  8  read data; valid the cycle after mem_rd

Behaviour:
- Reset (rst=0, async): state IDLE; fetch_ready, inst_valid, halt, mem_rd = 0; instruction, mem_addr = 0; byte counters cleared. Reset mid-fetch discards everything; no inst_valid follows.
- States: IDLE, READ, DONE, HALTED.
- fetch_ready = (state==IDLE) && !halt. Accept = fetch_req && fetch_ready && !flush, sampled at edge E0. PC latched at E0.
- Range check at accept: if fetch_pc > MEM_BYTES-4, go to HALTED and set halt after E0. No memory reads occur, inst_valid stays 0, and instruction is unchanged.
- READ: mem_rd=1 for exactly 4 cycles (after E0..E3), with mem_addr = pc, pc+1, pc+2, pc+3. The address never wraps, because the range check guarantees pc+3 <= MEM_BYTES-1. Byte k returns one cycle after its read and is captured at edges E2..E5. Byte 0 goes to bits [31:24], byte 3 to [7:0].
- DONE: entered at E5. The instruction register updates with the assembled word and inst_valid=1 for exactly one cycle (after E5). Latency from accept edge to inst_valid = 5 cycles. Next state IDLE, so fetch_ready returns the cycle after DONE.
- Halt word: if the assembled word == 32'h0, inst_valid still pulses with instruction=0. halt rises in the same cycle and the next state is HALTED.
- HALTED: fetch_ready=0, mem_rd=0, halt=1. Exit only via reset.
- instruction holds its last value between fetches. The output is registered; there is no combinational path from mem_rdata.
- flush during READ: next state IDLE, mem_rd drops after the edge, and late returning bytes are ignored (no inst_valid).
- flush during IDLE with fetch_req: flush wins and the request is not accepted.
- flush during DONE or HALTED: no effect.
- fetch_req while not ready is ignored; it does not need to be held, and the core re-presents it.
- Unaligned in-range PCs are legal.

Decomposition:
- Package imem_pkg: state enum (IDLE, READ, DONE, HALTED), INST_BYTES=4, HALT_WORD=32'h0.
- One sub-module, imem_byte_packer: a 4-byte shift/assembly register with load strobe, clear, and byte-count. It outputs the word plus a full flag.
- The FSM, address generation and halt logic stay in the top module.

Test Plan:
- Memory bytes 0..3 = 20,08,00,05; request pc=0 at E0 -> mem_addr 0,1,2,3 with mem_rd on E0..E3; inst_valid at cycle after E5 with instruction=32'h20080005; halt=0.
- Back-to-back: request pc=4 asserted continuously -> second accept exactly one cycle after the DONE cycle; instruction matches bytes 4..7.
- Bytes 8..11 = 0, request pc=8 -> inst_valid=1, instruction=0, halt=1 in the same cycle; subsequent fetch_req ignored (fetch_ready=0, no mem_rd).
- Request pc=61 (>60) -> no mem_rd, halt=1 one cycle after accept, inst_valid never asserts.
- Flush asserted the cycle after E1 during a pc=12 fetch -> mem_rd drops after that edge, no inst_valid, and fetch_ready=1 next cycle. A new pc=16 fetch then completes with the correct word.
- rst driven low asynchronously mid-READ (between edges) -> all outputs 0 immediately. After release, a pc=0 fetch completes normally with halt=0.
